// File: rtl/rc16_ctrl_pkg.sv
// Shared definitions for the 16-bit RISC main control unit.
// Holds the opcode map, ALUop and pc_src encodings, error codes, the control
// FSM state type and small opcode classification helpers.
package rc16_ctrl_pkg;

  // Opcode map (IR[15:12]); 0010..1001 are R-type, 1101/1110 are illegal.
  localparam logic [3:0] OP_LW     = 4'b0000;
  localparam logic [3:0] OP_SW     = 4'b0001;
  localparam logic [3:0] OP_R_LO   = 4'b0010;
  localparam logic [3:0] OP_R_HI   = 4'b1001;
  localparam logic [3:0] OP_BEQ    = 4'b1010;
  localparam logic [3:0] OP_BNE    = 4'b1011;
  localparam logic [3:0] OP_JMP    = 4'b1100;
  localparam logic [3:0] OP_ILL_A  = 4'b1101;
  localparam logic [3:0] OP_ILL_B  = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  // ALUop bus towards ALU_cu.
  localparam logic [1:0] ALUOP_RTYPE  = 2'b00;
  localparam logic [1:0] ALUOP_SW     = 2'b01;
  localparam logic [1:0] ALUOP_LW     = 2'b10;
  localparam logic [1:0] ALUOP_BRANCH = 2'b11;

  // PC source select.
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Halt reasons.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= OP_R_LO) && (op <= OP_R_HI);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILL_A) || (op == OP_ILL_B);
  endfunction

  function automatic logic [1:0] aluop_for(input logic [3:0] op);
    logic [1:0] res;
    case (op)
      OP_LW:   res = ALUOP_LW;
      OP_SW:   res = ALUOP_SW;
      OP_BEQ:  res = ALUOP_BRANCH;
      OP_BNE:  res = ALUOP_BRANCH;
      default: res = ALUOP_RTYPE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter for the main control unit.
// Counts consecutive cycles the FSM spends waiting on memory and flags the
// cycle in which the count would reach MEM_TIMEOUT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear count (state not waiting, or memory ready)
//   en         : waiting cycle, count up
//   expire     : this waiting cycle is the MEM_TIMEOUT-th one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LIMIT_M1 = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt_r;

  // Wait counter: clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (en) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The count already holds MEM_TIMEOUT-1 earlier waits, so this one is the limit.
  assign expire = en && (cnt_r == LIMIT_M1);

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit of the 16-bit RISC core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with the unified memory and
// drives the datapath enables plus the ALUop bus consumed by ALU_cu.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   run            : leave IDLE / keep fetching while high
//   opcode         : IR[15:12], captured in DECODE
//   rs_eq_rt       : equality comparator, used for BEQ/BNE in EXEC
//   mem_ready      : memory completes the current access this cycle
//   mem_req/mem_we : memory request and write qualifier
//   ir_write       : load IR; pc_write/pc_src : load PC and its source
//   ALUop/alu_src  : ALU_cu control and operand-B select
//   reg_write/reg_dst/mem_to_reg : register file writeback controls
//   halted/err_code: sticky stop flag and reason
module main_control_fsm
  import rc16_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       rs_eq_rt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] ALUop,
  output logic       alu_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [1:0] err_code
);

  state_t     state_r;
  logic [3:0] op_r;
  logic [1:0] err_r;

  logic   waiting_state_s;
  logic   timer_clr_s;
  logic   timer_en_s;
  logic   expire_s;
  logic   taken_s;
  state_t fetch_or_idle_s;

  // Wait counting only happens in the two memory-access states.
  always_comb begin
    waiting_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
    timer_clr_s     = !waiting_state_s || mem_ready;
    timer_en_s      = waiting_state_s && !mem_ready;
  end

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr_s),
    .en     (timer_en_s),
    .expire (expire_s)
  );

  // Branch decision and the "next fetch" target (drops run at instruction boundary).
  always_comb begin
    if (op_r == OP_BEQ) begin
      taken_s = rs_eq_rt;
    end else begin
      taken_s = !rs_eq_rt;
    end
    if (run) begin
      fetch_or_idle_s = ST_FETCH;
    end else begin
      fetch_or_idle_s = ST_IDLE;
    end
  end

  // Control state machine with captured opcode and halt reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 4'd0;
      err_r   <= ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            state_r <= ST_DECODE;
          end else if (expire_s) begin
            state_r <= ST_HALT;
            err_r   <= ERR_TIMEOUT;
          end
        end
        ST_DECODE: begin
          op_r <= opcode;
          if (opcode == OP_JMP) begin
            state_r <= fetch_or_idle_s;
          end else if (opcode == OP_HALT) begin
            state_r <= ST_HALT;
            err_r   <= ERR_NONE;
          end else if (is_illegal(opcode)) begin
            state_r <= ST_HALT;
            err_r   <= ERR_ILLEGAL;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_rtype(op_r)) begin
            state_r <= ST_WB;
          end else if ((op_r == OP_LW) || (op_r == OP_SW)) begin
            state_r <= ST_MEM;
          end else begin
            state_r <= fetch_or_idle_s;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (op_r == OP_LW) begin
              state_r <= ST_WB;
            end else begin
              state_r <= fetch_or_idle_s;
            end
          end else if (expire_s) begin
            state_r <= ST_HALT;
            err_r   <= ERR_TIMEOUT;
          end
        end
        ST_WB: begin
          state_r <= fetch_or_idle_s;
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore decode of datapath controls; FETCH strobes wait for mem_ready,
  // DECODE reacts to the live opcode for JMP, EXEC to rs_eq_rt for branches.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    ALUop      = ALUOP_RTYPE;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    err_code   = ERR_NONE;
    case (state_r)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_DECODE: begin
        if (opcode == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end else begin
          pc_write = 1'b0;
        end
      end
      ST_EXEC: begin
        ALUop   = aluop_for(op_r);
        alu_src = (op_r == OP_LW) || (op_r == OP_SW);
        if ((op_r == OP_BEQ) || (op_r == OP_BNE)) begin
          pc_write = taken_s;
          pc_src   = taken_s ? PC_SRC_BRANCH : PC_SRC_SEQ;
        end else begin
          pc_write = 1'b0;
        end
      end
      ST_MEM: begin
        // Address operands stay as in EXEC for the whole access.
        mem_req = 1'b1;
        mem_we  = (op_r == OP_SW);
        ALUop   = aluop_for(op_r);
        alu_src = 1'b1;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_r == OP_LW);
        reg_dst    = is_rtype(op_r);
      end
      ST_HALT: begin
        halted   = 1'b1;
        err_code = err_r;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: each driven cycle pushes the
// expected output vector; a negedge monitor pops and compares it.
module tb_main_control_fsm;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       rs_eq_rt;
  logic       mem_ready;
  logic       mem_req, mem_we, ir_write, pc_write;
  logic [1:0] pc_src, ALUop;
  logic       alu_src, reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];
  logic [14:0] obs;

  main_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .rs_eq_rt(rs_eq_rt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .ALUop(ALUop), .alu_src(alu_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted), .err_code(err_code)
  );

  // {mem_req, mem_we, ir_write, pc_write, pc_src, ALUop, alu_src, reg_write, reg_dst, mem_to_reg, halted, err_code}
  assign obs = {mem_req, mem_we, ir_write, pc_write, pc_src, ALUop,
                alu_src, reg_write, reg_dst, mem_to_reg, halted, err_code};

  localparam logic [14:0] Z    = 15'd0;
  localparam logic [14:0] F0   = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] F1   = {1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] DJ   = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] E_LW = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] E_SW = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] E_BT = {1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] E_BN = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] M_LW = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] M_SW = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] W_R  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam logic [14:0] W_LW = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [14:0] H00  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
  localparam logic [14:0] H01  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
  localparam logic [14:0] H10  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [14:0] got, input logic [14:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  // Monitor: compare at the falling edge, away from state updates.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  end

  task automatic step(input string tag, input logic r, input logic [3:0] opc,
                      input logic eq, input logic rdy, input logic [14:0] e);
    run       = r;
    opcode    = opc;
    rs_eq_rt  = eq;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step("reset", 1'b0, 4'd0, 1'b0, 1'b1, Z);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 4'd0; rs_eq_rt = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    step("idle_hold", 1'b0, 4'd0, 1'b0, 1'b1, Z);
    step("idle_go",   1'b1, 4'd0, 1'b0, 1'b1, Z);

    // R-type ADD, ready tied high: 4 cycles.
    step("add_fetch",  1'b1, 4'b0010, 1'b0, 1'b1, F1);
    step("add_decode", 1'b1, 4'b0010, 1'b0, 1'b1, Z);
    step("add_exec",   1'b1, 4'b1111, 1'b0, 1'b1, Z);
    step("add_wb",     1'b1, 4'b1111, 1'b0, 1'b1, W_R);

    // LW with 3 wait cycles in MEM.
    step("lw_fetch",  1'b1, 4'b0000, 1'b0, 1'b1, F1);
    step("lw_decode", 1'b1, 4'b0000, 1'b0, 1'b1, Z);
    step("lw_exec",   1'b1, 4'b0000, 1'b0, 1'b1, E_LW);
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 1'b1, 4'b0000, 1'b0, 1'b0, M_LW);
    step("lw_mem_rdy", 1'b1, 4'b0000, 1'b0, 1'b1, M_LW);
    step("lw_wb",      1'b1, 4'b0000, 1'b0, 1'b1, W_LW);

    // BEQ taken, then BNE with the same comparator value (not taken).
    step("beq_fetch",  1'b1, 4'b1010, 1'b1, 1'b1, F1);
    step("beq_decode", 1'b1, 4'b1010, 1'b1, 1'b1, Z);
    step("beq_exec",   1'b1, 4'b1010, 1'b1, 1'b1, E_BT);
    step("bne_fetch",  1'b1, 4'b1011, 1'b1, 1'b1, F1);
    step("bne_decode", 1'b1, 4'b1011, 1'b1, 1'b1, Z);
    step("bne_exec",   1'b1, 4'b1011, 1'b1, 1'b1, E_BN);

    // JMP: 2 cycles.
    step("jmp_fetch",  1'b1, 4'b1100, 1'b0, 1'b1, F1);
    step("jmp_decode", 1'b1, 4'b1100, 1'b0, 1'b1, DJ);

    // R-type with run dropped mid-instruction: completes, then IDLE.
    step("rrun_fetch",  1'b1, 4'b1001, 1'b0, 1'b1, F1);
    step("rrun_decode", 1'b0, 4'b1001, 1'b0, 1'b1, Z);
    step("rrun_exec",   1'b0, 4'b1001, 1'b0, 1'b1, Z);
    step("rrun_wb",     1'b0, 4'b1001, 1'b0, 1'b1, W_R);
    step("rrun_idle0",  1'b0, 4'b1001, 1'b0, 1'b1, Z);
    step("rrun_idle1",  1'b1, 4'b1001, 1'b0, 1'b1, Z);

    // SW, reset asserted mid-MEM: strobes drop in the same cycle.
    step("sw_fetch",    1'b1, 4'b0001, 1'b0, 1'b1, F1);
    step("sw_decode",   1'b1, 4'b0001, 1'b0, 1'b1, Z);
    step("sw_exec",     1'b1, 4'b0001, 1'b0, 1'b0, E_SW);
    step("sw_mem_wait", 1'b1, 4'b0001, 1'b0, 1'b0, M_SW);
    rst_n = 1'b0;
    step("sw_mem_rst",  1'b1, 4'b0001, 1'b0, 1'b0, Z);
    rst_n = 1'b1;
    step("post_rst_idle0", 1'b0, 4'b0001, 1'b0, 1'b1, Z);
    step("post_rst_idle1", 1'b0, 4'b0001, 1'b0, 1'b1, Z);
    step("post_rst_go",    1'b1, 4'b0001, 1'b0, 1'b1, Z);

    // Ready arrives on the 15th FETCH cycle: no error.
    for (int i = 0; i < 14; i++) step("to_edge_wait", 1'b1, 4'b1100, 1'b0, 1'b0, F0);
    step("to_edge_rdy",    1'b1, 4'b1100, 1'b0, 1'b1, F1);
    step("to_edge_decode", 1'b1, 4'b1100, 1'b0, 1'b1, DJ);

    // 15 FETCH waits: bus-error halt.
    for (int i = 0; i < 15; i++) step("to_wait", 1'b1, 4'b0010, 1'b0, 1'b0, F0);
    step("to_halt0", 1'b1, 4'b0010, 1'b0, 1'b1, H10);
    step("to_halt1", 1'b0, 4'b0010, 1'b0, 1'b0, H10);

    // Illegal opcode 1101, then toggles are ignored.
    do_reset();
    step("ill_idle",   1'b1, 4'b1101, 1'b0, 1'b1, Z);
    step("ill_fetch",  1'b1, 4'b1101, 1'b0, 1'b1, F1);
    step("ill_decode", 1'b1, 4'b1101, 1'b0, 1'b1, Z);
    for (int i = 0; i < 4; i++)
      step("ill_halt", 1'(i & 1), 4'b0000, 1'b1, 1'(~i & 1), H01);

    // HALT opcode: halted with no error.
    do_reset();
    step("hlt_idle",   1'b1, 4'b1111, 1'b0, 1'b1, Z);
    step("hlt_fetch",  1'b1, 4'b1111, 1'b0, 1'b1, F1);
    step("hlt_decode", 1'b1, 4'b1111, 1'b0, 1'b1, Z);
    step("hlt_halt",   1'b1, 4'b0010, 1'b0, 1'b1, H00);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
